// File: rtl/vp_pkg.sv
// vp_pkg: shared instruction format, opcodes and sequencer states for vp_instr_sequencer
package vp_pkg;
  localparam int INSTR_W = 13;
  localparam int OP_MSB = 12;
  localparam int OP_LSB = 11;
  localparam int REG_MSB = 10;
  localparam int REG_LSB = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 0;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;
  typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/vp_instr_sequencer_if.sv
// vp_instr_sequencer_if: host push side and processor issue side of the sequencer
interface vp_instr_sequencer_if import vp_pkg::*; #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH + 1);
  logic in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic in_ready;
  logic halt;
  logic vp_set;
  logic [INSTR_W-1:0] vp_instr;
  logic vp_issue;
  logic busy;
  logic [CW-1:0] fifo_count;
  modport master(output in_valid, in_instr, halt, input in_ready, vp_set, vp_instr, vp_issue, busy, fifo_count);
  modport slave(input in_valid, in_instr, halt, output in_ready, vp_set, vp_instr, vp_issue, busy, fifo_count);
endinterface

// File: rtl/vp_instr_fifo.sv
// vp_instr_fifo: synchronous instruction FIFO, active-low sync reset flushes pointers and count
module vp_instr_fifo import vp_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic [INSTR_W-1:0] din,
  input  logic pop,
  output logic [INSTR_W-1:0] dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rptr];
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/vp_instr_sequencer.sv
// vp_instr_sequencer: init pulse, FIFO-buffered issue and MUL stall for vector_processor.
// Defining VP_SEQ_STATS_EN adds saturating issued_count / mul_count outputs.
module vp_instr_sequencer import vp_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic reset,
`ifdef VP_SEQ_STATS_EN
  vp_instr_sequencer_if.slave bus,
  output logic [15:0] issued_count,
  output logic [15:0] mul_count
`else
  vp_instr_sequencer_if.slave bus
`endif
);
  localparam int SW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  localparam logic [0:0] ST_INIT = INIT;
  localparam logic [0:0] ST_RUN = RUN;
  logic [0:0] state;
  logic [SW-1:0] stall;
  logic [INSTR_W-1:0] head;
  logic empty, full, issue;
  assign issue = state == ST_RUN && !empty && !bus.halt && stall == '0;
  assign bus.in_ready = state == ST_RUN && !full;
  assign bus.busy = state == ST_INIT || !empty || stall != '0;
  vp_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(bus.in_valid && bus.in_ready),
    .din(bus.in_instr),
    .pop(issue),
    .dout(head),
    .count(bus.fifo_count),
    .full(full),
    .empty(empty)
  );
  // INIT lasts two cycles after reset: one with vp_set low-to-high, one with the pulse itself
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_INIT;
      bus.vp_set <= 1'b0;
      bus.vp_issue <= 1'b0;
      bus.vp_instr <= '0;
      stall <= '0;
    end else begin
      bus.vp_set <= state == ST_INIT && !bus.vp_set;
      if (state == ST_INIT && bus.vp_set) state <= ST_RUN;
      bus.vp_issue <= issue;
      bus.vp_instr <= issue ? head : '0;
      stall <= issue && head[OP_MSB:OP_LSB] == OP_MUL ? SW'(MUL_LAT - 1) :
               stall != '0 ? stall - 1'b1 : stall;
    end
  end
`ifdef VP_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      issued_count <= '0;
      mul_count <= '0;
    end else if (bus.vp_issue) begin
      if (issued_count != 16'hFFFF) issued_count <= issued_count + 1'b1;
      if (bus.vp_instr[OP_MSB:OP_LSB] == OP_MUL && mul_count != 16'hFFFF) mul_count <= mul_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_vp_instr_sequencer.sv
// tb_vp_instr_sequencer: directed checks of reset/init, issue latency, MUL stall, halt/full and mid-stall reset
module tb_vp_instr_sequencer;
  import vp_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int seen;
  vp_instr_sequencer_if #(.DEPTH(8)) bus ();
`ifdef VP_SEQ_STATS_EN
  logic [15:0] issued_count, mul_count;
  vp_instr_sequencer #(.DEPTH(8), .MUL_LAT(3)) dut (
    .clk(clk), .reset(reset), .bus(bus), .issued_count(issued_count), .mul_count(mul_count));
`else
  vp_instr_sequencer #(.DEPTH(8), .MUL_LAT(3)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [12:0] v);
    bus.in_valid = 1'b1;
    bus.in_instr = v;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.halt = 1'b0;
    step();
    step();
    chk("rst_vp_set", 32'(bus.vp_set), 0);
    chk("rst_vp_issue", 32'(bus.vp_issue), 0);
    chk("rst_vp_instr", 32'(bus.vp_instr), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_fifo_count", 32'(bus.fifo_count), 0);
    reset = 1'b1;
    step();
    chk("init_vp_set", 32'(bus.vp_set), 1);
    chk("init_in_ready", 32'(bus.in_ready), 0);
    step();
    chk("run_vp_set", 32'(bus.vp_set), 0);
    chk("run_in_ready", 32'(bus.in_ready), 1);
    chk("run_busy", 32'(bus.busy), 0);
    // single STORE: one-cycle latency
    push(13'h0C00);
    chk("st_count", 32'(bus.fifo_count), 1);
    chk("st_no_issue_yet", 32'(bus.vp_issue), 0);
    step();
    chk("st_issue", 32'(bus.vp_issue), 1);
    chk("st_instr", 32'(bus.vp_instr), 32'h0C00);
    chk("st_busy", 32'(bus.busy), 0);
    step();
    chk("st_issue_end", 32'(bus.vp_issue), 0);
    chk("st_instr_zero", 32'(bus.vp_instr), 0);
    // MUL then ADD: ADD issues 3 cycles after MUL
    bus.in_valid = 1'b1;
    bus.in_instr = 13'h1800;
    step();
    bus.in_instr = 13'h1000;
    step();
    bus.in_valid = 1'b0;
    chk("mul_issue", 32'(bus.vp_issue), 1);
    chk("mul_instr", 32'(bus.vp_instr), 32'h1800);
    step();
    chk("mul_stall1", 32'(bus.vp_issue), 0);
    chk("mul_stall1_busy", 32'(bus.busy), 1);
    step();
    chk("mul_stall2", 32'(bus.vp_issue), 0);
    step();
    chk("add_issue", 32'(bus.vp_issue), 1);
    chk("add_instr", 32'(bus.vp_instr), 32'h1000);
    step();
    chk("add_after", 32'(bus.vp_issue), 0);
    chk("add_busy", 32'(bus.busy), 0);
    // halt while filling: 8 accepted, 9th refused
    bus.halt = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("fill_ready", 32'(bus.in_ready), i < 8 ? 1 : 0);
      push(13'(i + 1));
      chk("fill_halted", 32'(bus.vp_issue), 0);
    end
    chk("full_count", 32'(bus.fifo_count), 8);
    chk("full_ready", 32'(bus.in_ready), 0);
    bus.halt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain_issue", 32'(bus.vp_issue), 1);
      chk("drain_instr", 32'(bus.vp_instr), 32'(i + 1));
    end
    step();
    chk("drain_done", 32'(bus.vp_issue), 0);
    chk("drain_count", 32'(bus.fifo_count), 0);
    // reset during MUL stall with 4 queued
    bus.halt = 1'b1;
    push(13'h1800);
    for (int i = 0; i < 4; i++) push(13'h1000 | 13'(i + 20));
    chk("q_count", 32'(bus.fifo_count), 5);
    bus.halt = 1'b0;
    step();
    chk("q_mul_issue", 32'(bus.vp_instr), 32'h1800);
    chk("q_count4", 32'(bus.fifo_count), 4);
    reset = 1'b0;
    step();
    chk("mr_count", 32'(bus.fifo_count), 0);
    chk("mr_issue", 32'(bus.vp_issue), 0);
    chk("mr_vp_set", 32'(bus.vp_set), 0);
    chk("mr_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    step();
    chk("mr_pulse", 32'(bus.vp_set), 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen += int'(bus.vp_issue);
    end
    chk("mr_no_stale_issue", 32'(seen), 0);
    chk("mr_pulse_gone", 32'(bus.vp_set), 0);
    chk("mr_busy_idle", 32'(bus.busy), 0);
`ifdef VP_SEQ_STATS_EN
    push(13'h0001);
    push(13'h0002);
    push(13'h0803);
    push(13'h1004);
    push(13'h1805);
    for (int i = 0; i < 6; i++) step();
    chk("stat_issued", 32'(issued_count), 5);
    chk("stat_mul", 32'(mul_count), 1);
    reset = 1'b0;
    step();
    chk("stat_issued_rst", 32'(issued_count), 0);
    chk("stat_mul_rst", 32'(mul_count), 0);
    reset = 1'b1;
    step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vp_instr_sequencer.md
# vp_instr_sequencer

Instruction front-end for `vector_processor`. It buffers 13-bit vector instructions from a host in a small FIFO and generates the one-cycle `set` initialisation pulse after reset. It then issues queued instructions to the processor's `instruction_set` input one at a time, and inserts stall cycles after multiplies so the multi-cycle multiply result is stable before the next instruction is issued.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `MUL_LAT`, 3: multiply occupancy in cycles, at least 1.

Ports:
- `clk`  in  1  : single clock; all logic on its rising edge.
- `reset`  in  1  : synchronous, active-low. 0 on a rising edge resets the block.
- `in_valid`  in  1  : host instruction valid.
- `in_instr`  in  13  : host instruction. Bits [12:11] are the opcode (00 LOAD, 01 STORE, 10 ADD, 11 MUL), bits [10:9] the register select, bits [8:0] the address.
- `in_ready`  out  1  : FIFO can accept an instruction this cycle.
- `halt`  in  1  : while 1, no new instruction is issued.
- `vp_set`  out  1  : one-cycle init pulse to the processor's `set`.
- `vp_instr`  out  13  : to the processor's `instruction_set`; forced to 0 when `vp_issue`=0.
- `vp_issue`  out  1  : `vp_instr` is valid this cycle; the processor executes only when it is 1.
- `busy`  out  1  : any of: INIT state, FIFO non-empty, or stall counter non-zero.
- `fifo_count`  out  $clog2(DEPTH+1)  : number of queued entries.

## Operation
- States:
  - INIT: `vp_set`=1 for exactly one cycle, then unconditional move to RUN.
  - RUN: issue when FIFO non-empty, `halt`=0 and stall counter is 0. Otherwise idle in RUN.
- Reset behaviour (`reset`=0 on an edge): state=INIT, FIFO flushed, stall counter=0.
  - During reset: `vp_set`=0, `vp_issue`=0, `vp_instr`=0, `in_ready`=0, `busy`=1, `fifo_count`=0.
- Push rule: `in_valid && in_ready` on an edge writes `in_instr` to the FIFO tail.
  - `in_ready` = (state==RUN) && (`fifo_count` < DEPTH). It is combinational from registered state.
  - A push while full is impossible because `in_ready`=0. A pop in the same cycle does not raise `in_ready`.
- Issue: pop the FIFO head and register it onto `vp_instr` with `vp_issue`=1 for one cycle. Issue order is FIFO order.
- MUL stall: issuing opcode 11 loads the stall counter with MUL_LAT-1. The counter decrements every cycle, including while `halt`=1. No issue occurs while it is non-zero. MUL_LAT=1 gives back-to-back issue.
- LOAD, STORE and ADD have no stall.
- Push and pop in the same cycle: `fifo_count` is unchanged. Read and write pointers wrap modulo DEPTH.
- `halt` asserted in the same cycle as an otherwise-legal issue: the issue is suppressed and the entry stays at the head.
- Reset mid-stall or with entries queued: queued instructions are discarded (not issued) and a fresh `vp_set` pulse follows.

## Timing
- `vp_set` is high during the first cycle after the first edge where `reset`=1.
- Earliest push: the edge after `vp_set` (the first RUN cycle).
- Acceptance to issue: an instruction accepted at edge E into an empty FIFO appears with `vp_issue`=1 after edge E+1. Latency is 1 cycle.
- Sustained throughput:
  - 1 instruction per cycle with no MUL.
  - After a MUL at edge E, the next issue is no earlier than edge E+MUL_LAT.
- `vp_instr` and `vp_issue` are registered outputs. `in_ready` and `busy` are combinational from registers only.

## Configuration
- `VP_SEQ_STATS_EN` defined: adds outputs `issued_count` [15:0] and `mul_count` [15:0].
  - Both are saturating counters at 16'hFFFF, cleared on reset.
  - They increment on each edge with `vp_issue`=1 (`mul_count` only for opcode 11).
- `VP_SEQ_STATS_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package `vp_pkg` holds:
  - `INSTR_W`=13.
  - Opcode constants OP_LOAD/OP_STORE/OP_ADD/OP_MUL.
  - Field position constants for opcode, register select and address.
  - State enum {INIT, RUN}.
- Sub-module `vp_instr_fifo`: synchronous FIFO with push/pop/count/full/empty and DEPTH parameter. The sequencer holds only the FSM, stall counter, output registers and stats.

## Test plan
- Reset held low 2 cycles, then released → all outputs 0 and `busy`=1 during reset. `vp_set`=1 for exactly one cycle after the first edge with `reset`=1. `in_ready`=1 on the next cycle.
- Push 13'b0110000000000 into an empty FIFO → next cycle `vp_issue`=1 with `vp_instr`=13'b0110000000000 for one cycle, then `vp_instr`=0 and `busy`=0.
- MUL_LAT=3: push 13'b1100000000000 then 13'b1000000000000 on consecutive cycles → ADD issues exactly 3 cycles after MUL, with `vp_issue`=0 in between.
- `halt`=1, push 9 instructions → 8 accepted, `fifo_count`=8, `in_ready`=0, 9th not accepted. Release `halt` → 8 issues on consecutive cycles in push order.
- Queue 4 entries behind a MUL, then assert `reset` for 1 cycle during the stall → `fifo_count`=0, no queued instruction ever issued, new `vp_set` pulse.
- With `VP_SEQ_STATS_EN`: issue 2 LOAD, 1 STORE, 1 ADD, 1 MUL → `issued_count`=5 and `mul_count`=1. Reset → both read 0.
